// File: rtl/uart_img_loader_if.sv
// Byte-stream and RAM-write bundle of the UART picture loader.
// slave = the loader itself, master = whoever feeds bytes and watches the RAM port.
interface uart_img_loader_if #(
    parameter int ADDR_W = 14
);
    logic [7:0]        pi_data;
    logic              pi_flag;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              frame_done;
    logic              frame_err;
    logic              busy;

    modport slave (
        input  pi_data, pi_flag,
        output wr_en, wr_addr, wr_data, frame_done, frame_err, busy
    );

    modport master (
        output pi_data, pi_flag,
        input  wr_en, wr_addr, wr_data, frame_done, frame_err, busy
    );
endinterface

// File: rtl/uart_img_loader.sv
// Finds the two-byte header in the UART byte stream and writes PIC_W*PIC_H pixels to RAM.
// Optional trailing mod-256 checksum byte: define IMG_LOADER_CHKSUM_EN.
module uart_img_loader #(
    parameter int          PIC_W       = 100,
    parameter int          PIC_H       = 100,
    parameter int          ADDR_W      = 14,
    parameter logic [7:0]  HDR0        = 8'h55,
    parameter logic [7:0]  HDR1        = 8'hAA,
    parameter int          TIMEOUT_CYC = 200_000
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    uart_img_loader_if.slave   bus
);
    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(PIC_W * PIC_H - 1);
    localparam int                TO_W     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0]   TO_MAX   = TO_W'(TIMEOUT_CYC);
    localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT_CYC - 1);

`ifdef IMG_LOADER_CHKSUM_EN
    typedef enum logic [1:0] {IDLE, HDR, DATA, CHK} state_t;
`else
    typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;
`endif

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] pix_cnt_reg, pix_cnt_next;
    logic [TO_W-1:0]   idle_cnt_reg, idle_cnt_next;
    logic              wr_en_reg, wr_en_next;
    logic [ADDR_W-1:0] wr_addr_reg, wr_addr_next;
    logic [7:0]        wr_data_reg, wr_data_next;
    logic              done_reg, done_next;
    logic              err_reg, err_next;
    logic              busy_reg;
    logic              timeout;
`ifdef IMG_LOADER_CHKSUM_EN
    logic [7:0]        sum_reg, sum_next;
`endif

    // A byte arriving in the firing cycle cancels the timeout.
    assign timeout = !bus.pi_flag && (state_reg != IDLE) && (idle_cnt_reg >= TO_LAST);

    always_comb begin
        state_next    = state_reg;
        pix_cnt_next  = pix_cnt_reg;
        wr_en_next    = 1'b0;
        wr_addr_next  = wr_addr_reg;
        wr_data_next  = wr_data_reg;
        done_next     = 1'b0;
        err_next      = 1'b0;
`ifdef IMG_LOADER_CHKSUM_EN
        sum_next      = sum_reg;
`endif
        if (bus.pi_flag || state_reg == IDLE)
            idle_cnt_next = '0;
        else if (idle_cnt_reg != TO_MAX)
            idle_cnt_next = idle_cnt_reg + 1'b1;
        else
            idle_cnt_next = idle_cnt_reg;

        if (timeout) begin
            state_next = IDLE;
            err_next   = 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.pi_flag && bus.pi_data == HDR0)
                        state_next = HDR;
                end
                HDR: begin
                    if (bus.pi_flag) begin
                        if (bus.pi_data == HDR1) begin
                            state_next   = DATA;
                            pix_cnt_next = '0;
`ifdef IMG_LOADER_CHKSUM_EN
                            sum_next     = '0;
`endif
                        end else if (bus.pi_data != HDR0) begin
                            state_next = IDLE;
                        end
                    end
                end
                DATA: begin
                    if (bus.pi_flag) begin
                        wr_en_next   = 1'b1;
                        wr_addr_next = pix_cnt_reg;
                        wr_data_next = bus.pi_data;
`ifdef IMG_LOADER_CHKSUM_EN
                        sum_next     = sum_reg + bus.pi_data;
`endif
                        if (pix_cnt_reg == LAST_PIX) begin
`ifdef IMG_LOADER_CHKSUM_EN
                            state_next = CHK;
`else
                            state_next = IDLE;
                            done_next  = 1'b1;
`endif
                        end else begin
                            pix_cnt_next = pix_cnt_reg + 1'b1;
                        end
                    end
                end
`ifdef IMG_LOADER_CHKSUM_EN
                CHK: begin
                    if (bus.pi_flag) begin
                        state_next = IDLE;
                        if (bus.pi_data == sum_reg)
                            done_next = 1'b1;
                        else
                            err_next  = 1'b1;
                    end
                end
`endif
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg    <= IDLE;
            pix_cnt_reg  <= '0;
            idle_cnt_reg <= '0;
            wr_en_reg    <= 1'b0;
            wr_addr_reg  <= '0;
            wr_data_reg  <= '0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
            busy_reg     <= 1'b0;
`ifdef IMG_LOADER_CHKSUM_EN
            sum_reg      <= '0;
`endif
        end else begin
            state_reg    <= state_next;
            pix_cnt_reg  <= pix_cnt_next;
            idle_cnt_reg <= idle_cnt_next;
            wr_en_reg    <= wr_en_next;
            wr_addr_reg  <= wr_addr_next;
            wr_data_reg  <= wr_data_next;
            done_reg     <= done_next;
            err_reg      <= err_next;
            // Registered copy of the state decode, so busy tracks state_reg exactly.
            busy_reg     <= (state_next != IDLE);
`ifdef IMG_LOADER_CHKSUM_EN
            sum_reg      <= sum_next;
`endif
        end
    end

    assign bus.wr_en      = wr_en_reg;
    assign bus.wr_addr    = wr_addr_reg;
    assign bus.wr_data    = wr_data_reg;
    assign bus.frame_done = done_reg;
    assign bus.frame_err  = err_reg;
    assign bus.busy       = busy_reg;
endmodule
